// File: rtl/scmp_bus_arb_pkg.sv
// rtl/scmp_bus_arb_pkg.sv - shared types and counter widths for the SC/MP bus arbiter
package scmp_bus_pak;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ADS,
        STROBE,
        END
    } BUS_ST_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } BUS_OWN_t;

    localparam int WAIT_CNT_W = 4;
    localparam int CONSEC_W   = 4;

endpackage

// File: rtl/scmp_bus_arb_prio.sv
// rtl/scmp_bus_arb_prio.sv - DMA-first two-way selection with CPU starvation guard
module scmp_bus_prio
    import scmp_bus_pak::*;
#(
    parameter int DMA_MAX_CONSEC = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     idle,
    input  logic     cpu_req,
    input  logic     dma_req,
    output BUS_OWN_t winner,
    output logic     gnt_valid
);

    localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(DMA_MAX_CONSEC);

    logic [CONSEC_W-1:0] consec;

    always_comb begin
        gnt_valid = idle & (cpu_req | dma_req);
        winner    = OWN_CPU;
        if (dma_req && (!cpu_req || consec != CONSEC_MAX)) begin
            winner = OWN_DMA;
        end
    end

    // Only DMA grants taken while the CPU is waiting count toward starvation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            consec <= '0;
        end else if (idle) begin
            if (gnt_valid && winner == OWN_DMA && cpu_req) begin
                if (consec != CONSEC_MAX) begin
                    consec <= consec + 1'b1;
                end
            end else begin
                consec <= '0;
            end
        end
    end

endmodule

// File: rtl/scmp_bus_arb.sv
// rtl/scmp_bus_arb.sv - SC/MP external bus controller arbitrating CPU and DMA cycles
module scmp_bus_arb
    import scmp_bus_pak::*;
#(
    parameter int ADDR_W         = 16,
    parameter int WAIT_STATES    = 2,
    parameter int DMA_MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic              dma_ack,
    output logic [7:0]        dma_rdata,
    output logic              breq,
    input  logic              enin,
    output logic              enout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_ads,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_hold
);

    BUS_ST_t                 state;
    BUS_ST_t                 state_nxt;
    BUS_OWN_t                owner;
    BUS_OWN_t                winner;
    logic                    gnt_valid;
    logic                    we_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [7:0]              wdata_q;
    logic [7:0]              rdata_q;
    logic [WAIT_CNT_W-1:0]   cnt;

    scmp_bus_prio #(
        .DMA_MAX_CONSEC(DMA_MAX_CONSEC)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .idle     (state == IDLE),
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .winner   (winner),
        .gnt_valid(gnt_valid)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = ARB;
            ARB:     if (enin) state_nxt = ADS;
            ADS:     state_nxt = STROBE;
            STROBE:  if (cnt == '0 && !mem_hold) state_nxt = END;
            END:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_CPU;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_valid) begin
                owner   <= winner;
                we_q    <= (winner == OWN_DMA) ? dma_we    : cpu_we;
                addr_q  <= (winner == OWN_DMA) ? dma_addr  : cpu_addr;
                wdata_q <= (winner == OWN_DMA) ? dma_wdata : cpu_wdata;
            end
            // Bus-facing copies change only when the bus is actually won.
            if (state == ARB && enin) begin
                mem_addr  <= addr_q;
                mem_wdata <= wdata_q;
            end
            if (state == ADS) begin
                cnt <= WAIT_CNT_W'(WAIT_STATES);
            end else if (state == STROBE && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == STROBE && cnt == '0 && !mem_hold && !we_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign breq      = (state != IDLE);
    assign enout     = enin & (state == IDLE) & ~cpu_req & ~dma_req;
    assign mem_ads   = (state == ADS);
    assign mem_rd    = (state == STROBE) & ~we_q;
    assign mem_wr    = (state == STROBE) & we_q;
    assign cpu_ack   = (state == END) & (owner == OWN_CPU);
    assign dma_ack   = (state == END) & (owner == OWN_DMA);
    assign cpu_rdata = rdata_q;
    assign dma_rdata = rdata_q;

endmodule

// File: tb/tb_scmp_bus_arb.sv
// tb/tb_scmp_bus_arb.sv - scoreboard bench for scmp_bus_arb with random two-port traffic
module tb_scmp_bus_arb;

    localparam int WS   = 2;
    localparam int DMAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic        breq, enout;
    logic        enin = 1'b1;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ads, mem_rd, mem_wr;
    logic        mem_hold = 1'b0;

    int  total = 0;
    int  bad = 0;
    bit  allow_hold = 0;

    typedef struct {
        logic        dma;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } exp_t;

    exp_t exp_q[$];

    scmp_bus_arb #(
        .ADDR_W(16), .WAIT_STATES(WS), .DMA_MAX_CONSEC(DMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .breq(breq), .enin(enin), .enout(enout),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ads(mem_ads), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_hold(mem_hold)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h83;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference arbiter: decides grants from the request levels seen while the bus is free.
    int consec = 0;
    bit busy = 0;
    always @(negedge clk) begin
        if (rst) begin
            consec = 0;
            busy   = 0;
        end else begin
            exp_t e;
            check("breq", breq, busy);
            check("enout", enout, enin && !busy && !cpu_req && !dma_req);
            if (!busy) begin
                if (cpu_req || dma_req) begin
                    e.dma = dma_req && !(cpu_req && consec == DMAX);
                    if (e.dma) begin
                        e.we = dma_we; e.addr = dma_addr; e.wdata = dma_wdata;
                        consec = cpu_req ? ((consec < DMAX) ? consec + 1 : DMAX) : 0;
                    end else begin
                        e.we = cpu_we; e.addr = cpu_addr; e.wdata = cpu_wdata;
                        consec = 0;
                    end
                    exp_q.push_back(e);
                    busy = 1;
                end else begin
                    consec = 0;
                end
            end else if (cpu_ack || dma_ack) begin
                busy = 0;
            end
        end
    end

    // Monitor and bus slave: pops the expected access at the address strobe and follows it to ack.
    int   phase = 0;
    int   idx = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (rst) begin
            phase = 0;
            mem_hold = 1'b0;
            exp_q.delete();
        end else begin
            case (phase)
                0: begin
                    check("ack_idle", {cpu_ack, dma_ack}, 2'b00);
                    check("strobe_idle", {mem_rd, mem_wr}, 2'b00);
                    if (mem_ads) begin
                        if (exp_q.size() == 0) begin
                            check("ads_unexpected", 1, 0);
                        end else begin
                            cur = exp_q.pop_front();
                            check("ads_addr", mem_addr, cur.addr);
                            if (cur.we) check("ads_wdata", mem_wdata, cur.wdata);
                            phase = 1;
                            idx = 0;
                        end
                    end
                end
                1: begin
                    check("ads_width", mem_ads, 0);
                    if (mem_rd || mem_wr) begin
                        idx++;
                        check("strobe_dir", {mem_wr, mem_rd}, cur.we ? 2'b10 : 2'b01);
                        check("strobe_addr", mem_addr, cur.addr);
                        if (cur.we) check("strobe_wdata", mem_wdata, cur.wdata);
                        mem_hold = allow_hold && ($urandom_range(0, 2) == 0);
                        if (idx > WS && !mem_hold) begin
                            mem_rdata = rd_val(cur.addr);
                            phase = 2;
                        end else begin
                            mem_rdata = ~rd_val(cur.addr);
                        end
                    end else begin
                        check("strobe_short", idx, WS + 1);
                        phase = 0;
                    end
                end
                default: begin
                    mem_hold  = 1'b0;
                    mem_rdata = 8'($urandom);
                    check("end_strobe", {mem_rd, mem_wr}, 2'b00);
                    check("end_ack", {cpu_ack, dma_ack}, cur.dma ? 2'b01 : 2'b10);
                    check("end_addr", mem_addr, cur.addr);
                    if (!cur.we) check("end_rdata", cur.dma ? dma_rdata : cpu_rdata, rd_val(cur.addr));
                    phase = 0;
                end
            endcase
        end
    end

    task automatic drive_port(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            bit ack;
            if (p == 0) begin
                cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom); cpu_req = 1'b1;
            end else begin
                dma_we = 1'($urandom); dma_addr = 16'($urandom); dma_wdata = 8'($urandom); dma_req = 1'b1;
            end
            do begin
                @(posedge clk); #1;
                t++;
                ack = (p == 0) ? cpu_ack : dma_ack;
                if (!ack && $urandom_range(0, 3) == 0) begin
                    if (p == 0) begin cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom); cpu_we = 1'($urandom); end
                    else        begin dma_addr = 16'($urandom); dma_wdata = 8'($urandom); dma_we = 1'($urandom); end
                end
            end while (!ack && t < 400);
            if (!ack) check(p == 0 ? "cpu_timeout" : "dma_timeout", 0, 1);
            if (p == 0) cpu_req = 1'b0; else dma_req = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int cyc;
        bit running;
        #100000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int  cyc;
        bit  running;
        #1;
        check("rst_outputs", {cpu_ack, dma_ack, breq, mem_ads, mem_rd, mem_wr}, 6'd0);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_enout", enout, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset in the middle of a read strobe
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_req = 1'b1;
        cyc = 0;
        while (!mem_rd && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check("rst_reach_strobe", mem_rd, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_strobe", {mem_rd, breq, cpu_ack, dma_ack, mem_ads}, 5'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_no_ack", {cpu_ack, dma_ack}, 2'b00);

        // Plain CPU read latency
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_req = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!cpu_ack && cyc < 50);
        check("cpu_read_latency", cyc, WS + 4);
        check("cpu_read_data", cpu_rdata, 8'hA5);
        check("cpu_read_dma_ack", dma_ack, 1'b0);
        cpu_req = 1'b0;

        // Bus withheld upstream: stay in ARB with no strobe
        @(posedge clk); #1;
        enin = 1'b0;
        dma_we = 1'b1; dma_addr = 16'h0F00; dma_wdata = 8'h3C; dma_req = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            check("arb_wait", {breq, mem_ads, enout}, 3'b100);
            @(posedge clk); #1;
        end
        enin = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!dma_ack && cyc < 50);
        check("dma_write_after_enin", cyc, WS + 3);
        dma_req = 1'b0;
        @(posedge clk); #1;
        check("enout_free", enout, 1'b1);

        // Random two-port traffic with hold, upstream grant loss and field churn
        allow_hold = 1;
        running = 1;
        fork
            begin
                fork
                    drive_port(0, 40);
                    drive_port(1, 40);
                join
                running = 0;
            end
            begin
                while (running) begin
                    @(posedge clk); #1;
                    enin = ($urandom_range(0, 4) != 0);
                end
                enin = 1'b1;
            end
        join

        repeat (4) @(posedge clk);
        #1;
        check("drain_queue", exp_q.size(), 0);
        check("drain_phase", phase, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
